// File: rtl/instr_arbiter.sv
// Round-robin arbiter sharing the datapath instruction port among NUM_REQ requesters,
// with credit throttling and an in-order read-tag FIFO. Optional: ARB_STRICT_PRIO_EN.

module instr_arbiter_lane (
    input  logic       valid_i,
    input  logic [1:0] op_i,
    input  logic       fifo_full_i,
    output logic       cand_o,
    output logic       nonread_o
);
    // Reads cannot be granted while the tag FIFO has no room for their tag.
    assign cand_o    = valid_i && !((op_i == 2'b10) && fifo_full_i);
    assign nonread_o = valid_i && (op_i != 2'b10);
endmodule

module instr_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int BYTE_ADDR_WIDTH  = 8,
    parameter int BANKS_ADDR_WIDTH = 2,
    parameter int INSTR_QUEUE_LEN  = 8,
    parameter int TAG_FIFO_LEN     = 8
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [NUM_REQ-1:0]                                req_valid,
    output logic [NUM_REQ-1:0]                                req_ready,
    input  logic [2*NUM_REQ-1:0]                              req_op,
    input  logic [NUM_REQ*(BYTE_ADDR_WIDTH+BANKS_ADDR_WIDTH)-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]                     req_din,
    output logic [1:0]                                        out_op,
    output logic [BYTE_ADDR_WIDTH+BANKS_ADDR_WIDTH-1:0]       out_addr,
    output logic [DATA_WIDTH-1:0]                             out_din,
    input  logic                                              instr_retire,
    input  logic                                              dp_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                             dp_dout,
    output logic [NUM_REQ-1:0]                                rsp_valid,
    output logic [DATA_WIDTH-1:0]                             rsp_data
);
    localparam int AW = BYTE_ADDR_WIDTH + BANKS_ADDR_WIDTH;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TAG_FIFO_LEN);
    localparam int CW = $clog2(INSTR_QUEUE_LEN + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       credits_q, credits_d;
    logic [PW-1:0]       rr_q, rr_d;
    logic [TW:0]         wr_q, rd_q;
    logic [PW-1:0]       tag_q [TAG_FIFO_LEN];
    logic [1:0]          out_op_q;
    logic [AW-1:0]       out_addr_q;
    logic [DATA_WIDTH-1:0] out_din_q, rsp_data_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;

    logic [1:0]            op_a   [NUM_REQ];
    logic [AW-1:0]         addr_a [NUM_REQ];
    logic [DATA_WIDTH-1:0] din_a  [NUM_REQ];
    logic [NUM_REQ-1:0]    cand, nonread, rr_mask;

    logic          fifo_full, fifo_empty, full_d, push, pop;
    logic [TW:0]   cnt, cnt_d;
    logic          grant_en, gnt_found, xfer, issue;
    logic [PW-1:0] gnt_idx;
    logic [1:0]    gnt_op;

    assign cnt        = wr_q - rd_q;
    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (cnt == (TW+1)'(TAG_FIFO_LEN));

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign op_a[i]   = req_op[2*i +: 2];
        assign addr_a[i] = req_addr[AW*i +: AW];
        assign din_a[i]  = req_din[DATA_WIDTH*i +: DATA_WIDTH];
        instr_arbiter_lane u_lane (
            .valid_i    (req_valid[i]),
            .op_i       (op_a[i]),
            .fifo_full_i(fifo_full),
            .cand_o     (cand[i]),
            .nonread_o  (nonread[i])
        );
    end

    function automatic logic [PW-1:0] wrap_idx(input int k);
        return PW'(k % NUM_REQ);
    endfunction

    always_comb begin
        rr_mask   = cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
`ifdef ARB_STRICT_PRIO_EN
        rr_mask[0] = 1'b0;
        if (cand[0]) gnt_found = 1'b1;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && rr_mask[wrap_idx(int'(rr_q) + i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_idx(int'(rr_q) + i);
            end
        end
    end

    assign grant_en  = (state_q == ISSUE) && (credits_q != '0);
    assign xfer      = grant_en && gnt_found;
    assign gnt_op    = op_a[gnt_idx];
    assign issue     = xfer && (gnt_op != 2'b00);
    assign push      = issue && (gnt_op == 2'b10);
    assign pop       = dp_rsp_valid && !fifo_empty;
    assign req_ready = xfer ? (NUM_REQ'(1) << gnt_idx) : '0;

    assign cnt_d  = cnt + (TW+1)'(push) - (TW+1)'(pop);
    assign full_d = (cnt_d == (TW+1)'(TAG_FIFO_LEN));

    always_comb begin
        rr_d = rr_q;
        if (xfer) begin
            rr_d = (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + PW'(1);
`ifdef ARB_STRICT_PRIO_EN
            if (gnt_idx == '0) rr_d = rr_q;
`endif
        end
    end

    // A retire at full credit has nothing to return and is dropped.
    always_comb begin
        credits_d = credits_q;
        if (issue && !instr_retire)
            credits_d = credits_q - CW'(1);
        else if (!issue && instr_retire && (credits_q < CW'(INSTR_QUEUE_LEN)))
            credits_d = credits_q + CW'(1);
    end

    // Parking on a full FIFO only when every waiting requester is a read.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if ((|req_valid) && (credits_q != '0)) state_d = ISSUE;
            ISSUE: begin
                if (credits_d == '0)                state_d = HOLD;
                else if (!(|req_valid))             state_d = IDLE;
                else if (full_d && !(|nonread))     state_d = HOLD;
            end
            HOLD:  if ((credits_q != '0) && (!fifo_full || (|nonread))) state_d = ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            credits_q   <= CW'(INSTR_QUEUE_LEN);
            rr_q        <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            out_op_q    <= 2'b00;
            out_addr_q  <= '0;
            out_din_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            credits_q   <= credits_d;
            rr_q        <= rr_d;
            out_op_q    <= issue ? gnt_op : 2'b00;
            rsp_valid_q <= pop ? (NUM_REQ'(1) << tag_q[rd_q[TW-1:0]]) : '0;
            if (issue) begin
                out_addr_q <= addr_a[gnt_idx];
                out_din_q  <= din_a[gnt_idx];
            end
            if (push) wr_q <= wr_q + (TW+1)'(1);
            if (pop) begin
                rd_q       <= rd_q + (TW+1)'(1);
                rsp_data_q <= dp_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_q[wr_q[TW-1:0]] <= gnt_idx;
    end

    assign out_op    = out_op_q;
    assign out_addr  = out_addr_q;
    assign out_din   = out_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_instr_arbiter.sv
// Directed bench for instr_arbiter: vector table for rotation, sequences for credits,
// read return order, full tag FIFO bypass, and asynchronous reset.

module tb_instr_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [7:0]   req_op = '0;
    logic [39:0]  req_addr = '0;
    logic [127:0] req_din = '0;
    logic [1:0]   out_op;
    logic [9:0]   out_addr;
    logic [31:0]  out_din;
    logic         instr_retire = 1'b0;
    logic         dp_rsp_valid = 1'b0;
    logic [31:0]  dp_dout = '0;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_data;

    int n_chk = 0;
    int n_fail = 0;
    int gq[$];

    always #5 clk = ~clk;

    instr_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_din(req_din),
        .out_op(out_op), .out_addr(out_addr), .out_din(out_din),
        .instr_retire(instr_retire), .dp_rsp_valid(dp_rsp_valid), .dp_dout(dp_dout),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op,
                           input logic [9:0] a, input logic [31:0] d);
        req_valid[i]         = v;
        req_op[2*i +: 2]     = op;
        req_addr[10*i +: 10] = a;
        req_din[32*i +: 32]  = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        instr_retire = 1'b0;
        dp_rsp_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs n cycles, records grants, checks the issue one cycle after each grant.
    task automatic run(input int n, input bit drop);
        logic [3:0] pg;
        logic [1:0] pop_;
        logic [9:0] pa;
        pg = '0; pop_ = '0; pa = '0;
        gq.delete();
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (drop) req_valid = req_valid & ~pg;
            @(negedge clk);
            chk("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
            if (c > 0) begin
                chk("issue_op", 64'(out_op), (pg != 0) ? 64'(pop_) : 64'd0);
                if (pg != 0 && pop_ != 0) chk("issue_addr", 64'(out_addr), 64'(pa));
            end
            pg = req_ready & req_valid;
            for (int i = 0; i < 4; i++) if (pg[i]) begin
                gq.push_back(i);
                pop_ = req_op[2*i +: 2];
                pa   = req_addr[10*i +: 10];
            end
        end
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [7:0]  op;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_op;
        logic [9:0]  exp_addr;
        logic [31:0] exp_din;
    } vec_t;

    vec_t tbl[6];

    initial begin
`ifdef ARB_STRICT_PRIO_EN
        tbl[0] = '{4'hF, 8'h55, 4'h0, 2'b00, 10'h000, 32'h0};
        tbl[1] = '{4'hF, 8'h55, 4'h1, 2'b00, 10'h000, 32'h0};
        tbl[2] = '{4'hF, 8'h55, 4'h1, 2'b01, 10'h010, 32'hA0};
        tbl[3] = '{4'hF, 8'h55, 4'h1, 2'b01, 10'h010, 32'hA0};
        tbl[4] = '{4'hF, 8'h55, 4'h1, 2'b01, 10'h010, 32'hA0};
        tbl[5] = '{4'hF, 8'h55, 4'h1, 2'b01, 10'h010, 32'hA0};
`else
        tbl[0] = '{4'hF, 8'h55, 4'h0, 2'b00, 10'h000, 32'h0};
        tbl[1] = '{4'hF, 8'h55, 4'h1, 2'b00, 10'h000, 32'h0};
        tbl[2] = '{4'hF, 8'h55, 4'h2, 2'b01, 10'h010, 32'hA0};
        tbl[3] = '{4'hF, 8'h55, 4'h4, 2'b01, 10'h011, 32'hA1};
        tbl[4] = '{4'hF, 8'h55, 4'h8, 2'b01, 10'h012, 32'hA2};
        tbl[5] = '{4'hF, 8'h55, 4'h1, 2'b01, 10'h013, 32'hA3};
`endif
        // Reset values
        do_reset();
        #1;
        chk("rst_ready", 64'(req_ready), 0);
        chk("rst_out_op", 64'(out_op), 0);
        chk("rst_out_addr", 64'(out_addr), 0);
        chk("rst_out_din", 64'(out_din), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rsp_data", 64'(rsp_data), 0);

        // Rotation with retire tied high
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 2'b01, 10'(16 + i), 32'(160 + i));
        instr_retire = 1'b1;
        for (int v = 0; v < 6; v++) begin
            @(posedge clk); #1;
            req_valid = tbl[v].valid;
            req_op    = tbl[v].op;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", v), 64'(req_ready), 64'(tbl[v].exp_ready));
            chk($sformatf("tbl%0d_op", v), 64'(out_op), 64'(tbl[v].exp_op));
            chk($sformatf("tbl%0d_addr", v), 64'(out_addr), 64'(tbl[v].exp_addr));
            chk($sformatf("tbl%0d_din", v), 64'(out_din), 64'(tbl[v].exp_din));
        end

        // Credit exhaustion then a single retire
        do_reset();
        set_req(2, 1'b1, 2'b01, 10'h033, 32'h77);
        run(30, 1'b0);
        chk("credit_grants", 64'(gq.size()), 8);
        chk("hold_ready", 64'(req_ready), 0);
        @(posedge clk); #1 instr_retire = 1'b1;
        @(posedge clk); #1 instr_retire = 1'b0;
        run(10, 1'b0);
        chk("retire_grants", 64'(gq.size()), 1);

        // Read return ordering
        do_reset();
        instr_retire = 1'b1;
        set_req(1, 1'b1, 2'b10, 10'h105, 32'h0);
        set_req(3, 1'b1, 2'b10, 10'h2A0, 32'h0);
        run(6, 1'b1);
        chk("rd_grants", 64'(gq.size()), 2);
        if (gq.size() == 2) begin
            chk("rd_first", 64'(gq[0]), 1);
            chk("rd_second", 64'(gq[1]), 3);
        end
        @(posedge clk); #1 dp_rsp_valid = 1'b1; dp_dout = 32'hDEADBEEF;
        @(posedge clk); #1 dp_rsp_valid = 1'b0;
        @(negedge clk);
        chk("rsp1_valid", 64'(rsp_valid), 64'h2);
        chk("rsp1_data", 64'(rsp_data), 64'hDEADBEEF);
        @(posedge clk); #1 dp_rsp_valid = 1'b1; dp_dout = 32'h12345678;
        @(negedge clk);
        chk("rsp_gap", 64'(rsp_valid), 0);
        @(posedge clk); #1 dp_rsp_valid = 1'b0;
        @(negedge clk);
        chk("rsp3_valid", 64'(rsp_valid), 64'h8);
        chk("rsp3_data", 64'(rsp_data), 64'h12345678);

        // Full tag FIFO: write bypasses a blocked read
        do_reset();
        instr_retire = 1'b1;
        set_req(0, 1'b1, 2'b10, 10'h0AA, 32'h0);
        run(14, 1'b0);
        chk("fill_grants", 64'(gq.size()), 8);
        set_req(1, 1'b1, 2'b01, 10'h055, 32'h5);
        run(6, 1'b1);
        chk("bypass_grants", 64'(gq.size()), 1);
        if (gq.size() >= 1) chk("bypass_idx", 64'(gq[0]), 1);
        @(posedge clk); #1 dp_rsp_valid = 1'b1; dp_dout = 32'hCAFE;
        @(posedge clk); #1 dp_rsp_valid = 1'b0;
        @(negedge clk);
        chk("pop_rsp0", 64'(rsp_valid), 64'h1);
        run(6, 1'b1);
        chk("unblock_grants", 64'(gq.size()), 1);
        if (gq.size() >= 1) chk("unblock_idx", 64'(gq[0]), 0);

        // Asynchronous reset with reads outstanding
        do_reset();
        instr_retire = 1'b1;
        set_req(0, 1'b1, 2'b10, 10'h0F0, 32'h0);
        run(3, 1'b0);
        chk("pre_rst_grants", 64'(gq.size()), 3);
        @(posedge clk); #2;
        chk("pre_rst_op", 64'(out_op), 64'h2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_op", 64'(out_op), 0);
        chk("async_rst_addr", 64'(out_addr), 0);
        chk("async_rst_ready", 64'(req_ready), 0);
        req_valid = '0;
        instr_retire = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1 dp_rsp_valid = 1'b1; dp_dout = 32'hBAD;
        @(posedge clk); #1 dp_rsp_valid = 1'b0;
        @(negedge clk);
        chk("stray_rsp", 64'(rsp_valid), 0);
        set_req(2, 1'b1, 2'b01, 10'h044, 32'h9);
        run(20, 1'b0);
        chk("post_rst_credits", 64'(gq.size()), 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
